// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, LSB-first, stop-bit check.
// Latency: falling edge on i_rxd to o_rxDone = 2 + DIV/2 + 9*DIV (+/-1) cycles, DIV = CLK_HZ/i_rxBaud.
// No backpressure: o_rxDone/o_rxFrameErr are single-cycle pulses, o_rxData holds the last good byte.
module uart_byte_rx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_rxd,
  input  logic [31:0] i_rxBaud,
  output logic [7:0]  o_rxData,
  output logic        o_rxDone,
  output logic        o_rxFrameErr,
  output logic        o_rxBusy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam logic [31:0] CLK_DIVIDEND = 32'(CLK_HZ);

  state_t      state, stateNext;
  logic        rxdMeta, rxdSync;
  logic [31:0] divReg, divNext;
  logic [31:0] cnt, cntNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [7:0]  shifter, shiftNext;
  logic [7:0]  rxDataReg, rxDataNext;
  logic        doneReg, doneNext;
  logic        errReg, errNext;
  logic [31:0] divNow;
  logic        tick;

  // A zero baud would be a divide-by-zero; it is unsupported, so just map it to 0.
  assign divNow = (i_rxBaud == 32'd0) ? 32'd0 : (CLK_DIVIDEND / i_rxBaud);
  assign tick   = (cnt == 32'd0);

  // Two-flop synchroniser for the asynchronous RXD pin; idles high.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rxdMeta <= 1'b1;
      rxdSync <= 1'b1;
    end else begin
      rxdMeta <= i_rxd;
      rxdSync <= rxdMeta;
    end
  end

  // State and datapath registers; reset discards any partially received byte.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      divReg    <= 32'd0;
      cnt       <= 32'd0;
      bitIdx    <= 3'd0;
      shifter   <= 8'h00;
      rxDataReg <= 8'h00;
      doneReg   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      state     <= stateNext;
      divReg    <= divNext;
      cnt       <= cntNext;
      bitIdx    <= bitIdxNext;
      shifter   <= shiftNext;
      rxDataReg <= rxDataNext;
      doneReg   <= doneNext;
      errReg    <= errNext;
    end
  end

  // Next-state logic: down counter reloaded on each state entry, tick when it reaches zero.
  always_comb begin
    stateNext  = state;
    divNext    = divReg;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    shiftNext  = shifter;
    rxDataNext = rxDataReg;
    doneNext   = 1'b0;
    errNext    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxdSync) begin
          // Baud is captured here so mid-frame changes cannot disturb this frame.
          stateNext = S_START;
          divNext   = divNow;
          cntNext   = (divNow >> 1) - 32'd1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxdSync) begin
            stateNext  = S_DATA;
            cntNext    = divReg - 32'd1;
            bitIdxNext = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            stateNext = S_IDLE;
          end
        end else begin
          cntNext = cnt - 32'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          shiftNext  = {rxdSync, shifter[7:1]};
          bitIdxNext = bitIdx + 3'd1;
          cntNext    = divReg - 32'd1;
          if (bitIdx == 3'd7) begin
            stateNext = S_STOP;
          end
        end else begin
          cntNext = cnt - 32'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxdSync) begin
            rxDataNext = shifter;
            doneNext   = 1'b1;
            stateNext  = S_IDLE;
          end else begin
            errNext   = 1'b1;
            stateNext = S_BREAK;
          end
        end else begin
          cntNext = cnt - 32'd1;
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break gives only one error pulse.
        if (rxdSync) begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  assign o_rxData     = rxDataReg;
  assign o_rxDone     = doneReg;
  assign o_rxFrameErr = errReg;
  assign o_rxBusy     = (state != S_IDLE);

endmodule
